pwm_duty_button_conditioner: RTL and testbench

Upstream input stage for the PWM generator in the Tiny Tapeout top level. Takes the two raw, asynchronous, bouncing push-button inputs (increase duty, decrease duty), synchronises and debounces them, and emits clean single-cycle step pulses that drive the PWM generator's increase and decrease inputs. Optional auto-repeat turns a held button into a steady stream of step pulses.

---
 rtl/pwm_btn_pkg.sv | 20 ++
 rtl/pwm_btn_debounce.sv | 54 +++++
 rtl/pwm_duty_button_conditioner.sv | 131 +++++++++++++
 tb/tb_pwm_duty_button_conditioner.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_btn_pkg.sv
// Shared definitions for the PWM duty push-button conditioner: press-state
// encoding, default cycle counts and counter/timer width helper.
package pwm_btn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } press_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 50000;
  localparam int unsigned DEF_HOLD_CYCLES     = 5000000;
  localparam int unsigned DEF_REPEAT_CYCLES   = 1000000;

  // Bits needed to hold the values 0..n.
  function automatic int unsigned tmr_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pwm_btn_debounce.sv
// One button channel: 2-flop synchroniser, debounce counter, debounced level
// register and single-cycle level-edge flags aligned with the level update.
module pwm_btn_debounce
  import pwm_btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level_o,
  output logic level_nxt_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CW = tmr_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          toggle;

  always_comb begin
    toggle  = (s2_q != level_q) && (cnt_q == CNT_LAST);
    level_d = level_q ^ toggle;
    if ((s2_q == level_q) || toggle) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= btn_raw;
      s2_q    <= s1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o     = level_q;
  assign level_nxt_o = level_d;
  assign rise_o      = toggle & ~level_q;
  assign fall_o      = toggle & level_q;

endmodule

// File: rtl/pwm_duty_button_conditioner.sv
// Debounced inc/dec step-pulse generator feeding the PWM generator.
// Optional auto-repeat of held buttons: define PWM_BTN_AUTOREPEAT_EN.
module pwm_duty_button_conditioner
  import pwm_btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic btn_inc_raw,
  input  logic btn_dec_raw,
  output logic inc_pulse,
  output logic dec_pulse,
  output logic inc_level,
  output logic dec_level
);

  // Single-cycle pulses need at least two cycles between repeat strobes.
  if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_cfg
    $error("pwm_duty_button_conditioner: illegal cycle-count parameters");
  end

  logic [1:0] raw, lvl, lvl_nxt, rise, fall;
  logic [1:0] pulse_q, pulse_d;
  logic       conflict;

  press_state_e state_q [2];
  press_state_e state_d [2];

  assign raw = {btn_dec_raw, btn_inc_raw};

  for (genvar g = 0; g < 2; g++) begin : g_chan
    pwm_btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_raw    (raw[g]),
      .level_o    (lvl[g]),
      .level_nxt_o(lvl_nxt[g]),
      .rise_o     (rise[g]),
      .fall_o     (fall[g])
    );
  end

`ifdef PWM_BTN_AUTOREPEAT_EN
  localparam int unsigned TW = (tmr_width(HOLD_CYCLES) > tmr_width(REPEAT_CYCLES)) ?
                               tmr_width(HOLD_CYCLES) : tmr_width(REPEAT_CYCLES);
  localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_CYCLES - 1);

  logic [TW-1:0] timer_q [2];
  logic [TW-1:0] timer_d [2];
`endif

  // Conflict is judged on the levels that take effect this edge, so a
  // simultaneous rise of both buttons already suppresses both press pulses.
  always_comb begin
    conflict = lvl_nxt[0] & lvl_nxt[1];
    for (int unsigned i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      pulse_d[i] = 1'b0;
`ifdef PWM_BTN_AUTOREPEAT_EN
      timer_d[i] = timer_q[i];
`endif
      if (fall[i]) begin
        state_d[i] = IDLE;
`ifdef PWM_BTN_AUTOREPEAT_EN
        timer_d[i] = '0;
`endif
      end else if (rise[i]) begin
        state_d[i] = HELD;
        pulse_d[i] = 1'b1;
`ifdef PWM_BTN_AUTOREPEAT_EN
        timer_d[i] = '0;
      end else if (!conflict) begin
        case (state_q[i])
          HELD: begin
            if (timer_q[i] == HOLD_LAST) begin
              state_d[i] = REPEAT;
              pulse_d[i] = 1'b1;
              timer_d[i] = '0;
            end else begin
              timer_d[i] = timer_q[i] + 1'b1;
            end
          end
          REPEAT: begin
            if (timer_q[i] == REPEAT_LAST) begin
              pulse_d[i] = 1'b1;
              timer_d[i] = '0;
            end else begin
              timer_d[i] = timer_q[i] + 1'b1;
            end
          end
          default: ;
        endcase
`endif
      end
      pulse_d[i] = pulse_d[i] & ena & ~conflict;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_q <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        state_q[i] <= IDLE;
`ifdef PWM_BTN_AUTOREPEAT_EN
        timer_q[i] <= '0;
`endif
      end
    end else begin
      pulse_q <= pulse_d;
      for (int unsigned i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
`ifdef PWM_BTN_AUTOREPEAT_EN
        timer_q[i] <= timer_d[i];
`endif
      end
    end
  end

  assign inc_pulse = pulse_q[0];
  assign dec_pulse = pulse_q[1];
  assign inc_level = lvl[0];
  assign dec_level = lvl[1];

endmodule

// File: tb/tb_pwm_duty_button_conditioner.sv
// Directed self-checking bench for pwm_duty_button_conditioner
// (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8).
module tb_pwm_duty_button_conditioner;

`ifdef PWM_BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, ena, btn_inc_raw, btn_dec_raw;
  logic inc_pulse, dec_pulse, inc_level, dec_level;

  int checks   = 0;
  int failures = 0;
  int inc_cnt  = 0;
  int dec_cnt  = 0;
  int b2b      = 0;
  logic inc_prev = 1'b0;
  logic dec_prev = 1'b0;

  pwm_duty_button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (20),
    .REPEAT_CYCLES  (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .btn_inc_raw(btn_inc_raw),
    .btn_dec_raw(btn_dec_raw),
    .inc_pulse  (inc_pulse),
    .dec_pulse  (dec_pulse),
    .inc_level  (inc_level),
    .dec_level  (dec_level)
  );

  always #5 clk = ~clk;

  // Pulse bookkeeping, sampled just after each active edge.
  always @(posedge clk) begin
    #1;
    if (inc_pulse) inc_cnt++;
    if (dec_pulse) dec_cnt++;
    if ((inc_pulse && inc_prev) || (dec_pulse && dec_prev)) b2b++;
    inc_prev = inc_pulse;
    dec_prev = dec_pulse;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; btn_inc_raw = 1'b0; btn_dec_raw = 1'b0;
    idle(3);
    checks++;
    if ({inc_pulse, dec_pulse, inc_level, dec_level} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=0000", {inc_pulse, dec_pulse, inc_level, dec_level});
    end
    rst_n = 1'b1;
    idle(3);
    checks++;
    if ({inc_pulse, dec_pulse, inc_level, dec_level} !== 4'b0000) begin
      failures++;
      $display("FAIL post_reset_idle got=%b want=0000", {inc_pulse, dec_pulse, inc_level, dec_level});
    end
  endtask

  task automatic test_press_latency();
    int c0;
    c0 = inc_cnt;
    btn_inc_raw = 1'b1;
    idle(5);
    checks++;
    if ({inc_level, inc_pulse} !== 2'b00) begin
      failures++;
      $display("FAIL press_early got=%b want=00", {inc_level, inc_pulse});
    end
    idle(1);
    checks++;
    if ({inc_level, inc_pulse, dec_level, dec_pulse} !== 4'b1100) begin
      failures++;
      $display("FAIL press_edge got=%b want=1100", {inc_level, inc_pulse, dec_level, dec_pulse});
    end
    idle(1);
    checks++;
    if ({inc_level, inc_pulse} !== 2'b10) begin
      failures++;
      $display("FAIL press_pulse_drop got=%b want=10", {inc_level, inc_pulse});
    end
    btn_inc_raw = 1'b0;
    idle(5);
    checks++;
    if (inc_level !== 1'b1) begin
      failures++;
      $display("FAIL release_early got=%b want=1", inc_level);
    end
    idle(1);
    checks++;
    if (inc_level !== 1'b0) begin
      failures++;
      $display("FAIL release_edge got=%b want=0", inc_level);
    end
    idle(4);
    checks++;
    if (inc_cnt - c0 !== 1) begin
      failures++;
      $display("FAIL press_pulse_count got=%0d want=1", inc_cnt - c0);
    end
  endtask

  task automatic test_bounce();
    int c0;
    c0 = dec_cnt;
    for (int r = 0; r < 5; r++) begin
      btn_dec_raw = 1'b1;
      idle(3);
      btn_dec_raw = 1'b0;
      idle(1);
    end
    checks++;
    if ({dec_level, dec_cnt - c0} !== {1'b0, 32'd0}) begin
      failures++;
      $display("FAIL bounce_quiet level=%b pulses=%0d want level=0 pulses=0", dec_level, dec_cnt - c0);
    end
    btn_dec_raw = 1'b1;
    idle(5);
    checks++;
    if ({dec_level, dec_pulse} !== 2'b00) begin
      failures++;
      $display("FAIL bounce_early got=%b want=00", {dec_level, dec_pulse});
    end
    idle(1);
    checks++;
    if ({dec_level, dec_pulse} !== 2'b11) begin
      failures++;
      $display("FAIL bounce_settle got=%b want=11", {dec_level, dec_pulse});
    end
    idle(4);
    btn_dec_raw = 1'b0;
    idle(8);
    checks++;
    if ({dec_level, dec_cnt - c0} !== {1'b0, 32'd1}) begin
      failures++;
      $display("FAIL bounce_single level=%b pulses=%0d want level=0 pulses=1", dec_level, dec_cnt - c0);
    end
  endtask

  task automatic test_autorepeat();
    logic [65:0] obs, exp;
    obs = '0; exp = '0;
    for (int k = 20; k <= 52; k += 8) exp[k] = AR;
    btn_inc_raw = 1'b1;
    idle(6);
    checks++;
    if (inc_pulse !== 1'b1) begin
      failures++;
      $display("FAIL repeat_press got=%b want=1", inc_pulse);
    end
    for (int k = 1; k <= 65; k++) begin
      @(negedge clk);
      obs[k] = inc_pulse;
      if (k == 53) btn_inc_raw = 1'b0;
    end
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL repeat_pattern got=%h want=%h", obs, exp);
    end
    checks++;
    if (inc_level !== 1'b0) begin
      failures++;
      $display("FAIL repeat_release got=%b want=0", inc_level);
    end
    idle(4);
  endtask

  task automatic test_conflict();
    logic [50:0] obs, exp;
    int d0;
    obs = '0; exp = '0;
    exp[36] = AR; exp[44] = AR;
    d0 = dec_cnt;
    btn_inc_raw = 1'b1;
    idle(6);
    checks++;
    if (inc_pulse !== 1'b1) begin
      failures++;
      $display("FAIL conflict_press got=%b want=1", inc_pulse);
    end
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      obs[k] = inc_pulse;
      if (k == 4) btn_dec_raw = 1'b1;
      if (k == 20) btn_dec_raw = 1'b0;
      if (k == 45) btn_inc_raw = 1'b0;
      if (k == 12) begin
        checks++;
        if (dec_level !== 1'b1) begin
          failures++;
          $display("FAIL conflict_dec_level got=%b want=1", dec_level);
        end
      end
    end
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL conflict_inc_pattern got=%h want=%h", obs, exp);
    end
    idle(8);
    checks++;
    if ({inc_level, dec_level, dec_cnt - d0} !== {2'b00, 32'd0}) begin
      failures++;
      $display("FAIL conflict_dec_pulses levels=%b pulses=%0d want levels=00 pulses=0",
               {inc_level, dec_level}, dec_cnt - d0);
    end
  endtask

  task automatic test_ena();
    int c0;
    c0 = inc_cnt;
    ena = 1'b0;
    btn_inc_raw = 1'b1;
    idle(6);
    checks++;
    if ({inc_level, inc_pulse} !== 2'b10) begin
      failures++;
      $display("FAIL ena_low_press got=%b want=10", {inc_level, inc_pulse});
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 3) ena = 1'b1;
      if (k == 10) btn_inc_raw = 1'b0;
    end
    checks++;
    if ({inc_level, inc_cnt - c0} !== {1'b0, 32'd0}) begin
      failures++;
      $display("FAIL ena_no_replay level=%b pulses=%0d want level=0 pulses=0", inc_level, inc_cnt - c0);
    end
    idle(4);
  endtask

  task automatic test_reset_mid_hold();
    btn_inc_raw = 1'b1;
    idle(6);
    checks++;
    if (inc_pulse !== 1'b1) begin
      failures++;
      $display("FAIL rst_hold_press got=%b want=1", inc_pulse);
    end
    idle(28);
    checks++;
    if ({inc_level, inc_pulse} !== {1'b1, AR}) begin
      failures++;
      $display("FAIL rst_hold_before got=%b want=%b", {inc_level, inc_pulse}, {1'b1, AR});
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({inc_pulse, dec_pulse, inc_level, dec_level} !== 4'b0000) begin
      failures++;
      $display("FAIL rst_async_drop got=%b want=0000", {inc_pulse, dec_pulse, inc_level, dec_level});
    end
    idle(2);
    rst_n = 1'b1;
    idle(5);
    checks++;
    if ({inc_level, inc_pulse} !== 2'b00) begin
      failures++;
      $display("FAIL rst_repress_early got=%b want=00", {inc_level, inc_pulse});
    end
    idle(1);
    checks++;
    if ({inc_level, inc_pulse} !== 2'b11) begin
      failures++;
      $display("FAIL rst_repress got=%b want=11", {inc_level, inc_pulse});
    end
    btn_inc_raw = 1'b0;
    idle(10);
  endtask

  task automatic test_back_to_back();
    checks++;
    if (b2b !== 0) begin
      failures++;
      $display("FAIL back_to_back got=%0d want=0", b2b);
    end
  endtask

  initial begin
    test_reset();
    test_press_latency();
    test_bounce();
    test_autorepeat();
    test_conflict();
    test_ena();
    test_reset_mid_hold();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
